// File: rtl/plate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plate_pkg: shared widths, sentinels and FSM encoding for the plate   |
// | character scheduler.                          Revision: 1.0           |
// +----------------------------------------------------------------------+
package plate_pkg;
   localparam int NUM_CHARS = 7;
   localparam int CHAR_W    = 4;
   localparam int DIFF_W    = 16;

   localparam logic [CHAR_W-1:0] CHAR_INVALID = 4'hF;
   localparam logic [DIFF_W-1:0] DIFF_TIMEOUT = 16'hFFFF;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;
endpackage
`default_nettype wire

// File: rtl/sched_timeout_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sched_timeout_timer: per-slot wait timer, expires at TIMEOUT_CYC-1;  |
// | TIMEOUT_CYC of 0 never expires.               Revision: 1.0           |
// +----------------------------------------------------------------------+
module sched_timeout_timer #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT_CYC == 0) begin : g_disabled
         logic unused;
         assign unused  = &{1'b0, clk, rst_n, clear, enable};
         assign expired = 1'b0;
      end else begin : g_count
         localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
         logic [CNT_W-1:0] count;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               count <= '0;
            else if (clear)
               count <= '0;
            else if (enable)
               count <= count + 1'b1;
         end

         assign expired = enable && (count == CNT_W'(TIMEOUT_CYC - 1));
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/plate_char_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plate_char_scheduler: drives the shared matcher over every character |
// | slot of a frame. Option macro: SCHED_EARLY_ABORT_EN. Revision: 1.0    |
// +----------------------------------------------------------------------+
module plate_char_scheduler #(
   parameter int NUM_CHARS   = plate_pkg::NUM_CHARS,
   parameter int TIMEOUT_CYC = 4096,
   parameter int SLOT_W      = 3
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   seg_valid,
   output logic                                   seg_ready,
   input  logic [15:0]                            max_diff,
   input  logic                                   err_clr,
   output logic                                   mt_req,
   output logic [SLOT_W-1:0]                      mt_slot,
   input  logic                                   mt_ack,
   input  logic                                   mt_done,
   input  logic [3:0]                             mt_index,
   input  logic [15:0]                            mt_diff,
   output logic [NUM_CHARS*plate_pkg::CHAR_W-1:0] char_index_c,
   output logic [NUM_CHARS*plate_pkg::DIFF_W-1:0] char_diff_c,
   output logic                                   char_valid_c,
   output logic                                   busy,
   output logic                                   timeout_err,
   output logic [7:0]                             drop_cnt
);
   import plate_pkg::*;

   logic [1:0]                  state, state_nxt;
   logic [SLOT_W-1:0]           slot;
   logic [NUM_CHARS*CHAR_W-1:0] shadow_index, index_merged;
   logic [NUM_CHARS*DIFF_W-1:0] shadow_diff, diff_merged;
   logic [CHAR_W-1:0]           lane_index;
   logic [DIFF_W-1:0]           lane_diff;
   logic                        expired, result_evt, timeout_evt, last_slot, abort;

   sched_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state != ST_WAIT),
      .enable  (state == ST_WAIT),
      .expired (expired)
   );

   // A real result always beats a timer expiring in the same cycle.
   assign result_evt  = (state == ST_WAIT) && (mt_done || expired);
   assign timeout_evt = (state == ST_WAIT) && expired && !mt_done;
   assign last_slot   = (slot == SLOT_W'(NUM_CHARS - 1));

`ifdef SCHED_EARLY_ABORT_EN
   logic lane_bad;
   assign lane_bad = timeout_evt || (mt_diff > max_diff);
   assign abort    = lane_bad;
`else
   assign abort    = 1'b0;
`endif

   always_comb begin
      if (timeout_evt) begin
         lane_index = CHAR_INVALID;
         lane_diff  = DIFF_TIMEOUT;
      end else begin
         lane_index = (mt_diff > max_diff) ? CHAR_INVALID : mt_index;
         lane_diff  = mt_diff;
      end
   end

   // Slot 0 occupies the most significant lane.
   always_comb begin
      index_merged = shadow_index;
      diff_merged  = shadow_diff;
      for (int i = 0; i < NUM_CHARS; i++) begin
         if (slot == SLOT_W'(i)) begin
            index_merged[(NUM_CHARS-1-i)*CHAR_W +: CHAR_W] = lane_index;
            diff_merged[(NUM_CHARS-1-i)*DIFF_W +: DIFF_W]  = lane_diff;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (seg_valid) state_nxt = ST_REQ;
         ST_REQ:  if (mt_ack)    state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (result_evt) begin
               if (abort)
                  state_nxt = ST_IDLE;
               else if (last_slot)
                  state_nxt = ST_DONE;
               else
                  state_nxt = ST_REQ;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      seg_ready    = (state == ST_IDLE);
      busy         = (state != ST_IDLE);
      mt_req       = (state == ST_REQ);
      char_valid_c = (state == ST_DONE);
   end

   assign mt_slot = slot;

   // Output buses load on the edge into DONE so they are valid with the pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot         <= '0;
         shadow_index <= '0;
         shadow_diff  <= '0;
         char_index_c <= '0;
         char_diff_c  <= '0;
         timeout_err  <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         if (state == ST_IDLE && seg_valid)
            slot <= '0;
         else if (result_evt && !last_slot)
            slot <= slot + SLOT_W'(1);

         if (result_evt) begin
            shadow_index <= index_merged;
            shadow_diff  <= diff_merged;
         end

         if (result_evt && last_slot && !abort) begin
            char_index_c <= index_merged;
            char_diff_c  <= diff_merged;
         end

         if (timeout_evt)
            timeout_err <= 1'b1;
         else if (err_clr)
            timeout_err <= 1'b0;

         if (seg_valid && state != ST_IDLE && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_plate_char_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_plate_char_scheduler: randomized matcher model with a frame-level |
// | reference for lanes, latency, errors and drops.   Revision: 1.0       |
// +----------------------------------------------------------------------+
module tb_plate_char_scheduler;
   localparam int NC = 7;
   localparam int SW = 3;
   localparam int TO = 16;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          seg_valid = 1'b0, err_clr = 1'b0, mt_ack = 1'b0, mt_done = 1'b0;
   logic [15:0]   max_diff = '0, mt_diff = '0;
   logic [3:0]    mt_index = '0;
   logic          seg_ready, mt_req, char_valid_c, busy, timeout_err;
   logic [SW-1:0] mt_slot;
   logic [NC*4-1:0]  char_index_c;
   logic [NC*16-1:0] char_diff_c;
   logic [7:0]    drop_cnt;

   always #5 clk = ~clk;

   plate_char_scheduler #(.NUM_CHARS(NC), .TIMEOUT_CYC(TO), .SLOT_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_ready(seg_ready),
      .max_diff(max_diff), .err_clr(err_clr), .mt_req(mt_req), .mt_slot(mt_slot),
      .mt_ack(mt_ack), .mt_done(mt_done), .mt_index(mt_index), .mt_diff(mt_diff),
      .char_index_c(char_index_c), .char_diff_c(char_diff_c), .char_valid_c(char_valid_c),
      .busy(busy), .timeout_err(timeout_err), .drop_cnt(drop_cnt)
   );

   int n_assert = 0, n_fail = 0;

   // Per-slot matcher behaviour: ack after f_ack REQ cycles, done after f_done WAIT cycles (-1 = never).
   int          f_ack[NC], f_done[NC];
   logic [3:0]  f_idx[NC];
   logic [15:0] f_dif[NC];
   bit          f_spur = 0, f_clr = 0;
   int          f_drops = 0, stop_slot = -1;

   int          o_lat, o_slot_bad, o_emit;
   bit          o_valid, o_hung;
   logic [NC*4-1:0]  o_cidx;
   logic [NC*16-1:0] o_cdiff;

   logic [NC*4-1:0]  exp_idx = '0;
   logic [NC*16-1:0] exp_diff = '0;
   bit          exp_err = 0, exp_valid = 0;
   int          exp_lat = 0, exp_drop = 0;

   task automatic set_slots(input int ack, input int done, input logic [15:0] dif);
      for (int i = 0; i < NC; i++) begin
         f_ack[i] = ack; f_done[i] = done; f_idx[i] = 4'(i + 1); f_dif[i] = dif;
      end
      f_spur = 0; f_clr = 0; f_drops = 0;
   endtask

   // Reference: walk the slots in order applying the frame rules.
   task automatic model_frame(input logic [15:0] md);
      logic [NC*4-1:0]  ni;
      logic [NC*16-1:0] nd;
      bit ab, to;
      int lat;
      ni = exp_idx; nd = exp_diff; ab = 0; lat = 1;
      for (int i = 0; i < NC && !ab; i++) begin
         to = (f_done[i] < 0) || (f_done[i] > TO - 1);
         ni[(NC-1-i)*4 +: 4]   = to ? 4'hF : ((f_dif[i] > md) ? 4'hF : f_idx[i]);
         nd[(NC-1-i)*16 +: 16] = to ? 16'hFFFF : f_dif[i];
         lat += f_ack[i] + 1 + (to ? TO : f_done[i] + 1);
         if (f_clr && (to || f_done[i] == TO - 1)) exp_err = to;
         else if (to) exp_err = 1;
`ifdef SCHED_EARLY_ABORT_EN
         if (to || f_dif[i] > md) ab = 1;
`endif
      end
      exp_valid = !ab;
      if (!ab) begin exp_idx = ni; exp_diff = nd; exp_lat = lat; end
      exp_drop = (exp_drop + o_emit > 255) ? 255 : exp_drop + o_emit;
   endtask

   task automatic run_frame(input logic [15:0] md);
      int s, req_cnt, wait_cnt;
      bit in_wait, prev_req;
      s = -1; req_cnt = 0; wait_cnt = 0; in_wait = 0; prev_req = 0;
      o_valid = 0; o_lat = -1; o_slot_bad = 0; o_emit = 0; o_hung = 1;
      @(negedge clk);
      max_diff = md; seg_valid = 1'b1;
      for (int cyc = 1; cyc < 4000; cyc++) begin
         @(negedge clk);
         seg_valid = 1'b0; mt_ack = 1'b0; mt_done = 1'b0; err_clr = 1'b0;
         mt_index = 4'($urandom); mt_diff = 16'($urandom);
         if (char_valid_c) begin
            o_valid = 1; o_lat = cyc; o_cidx = char_index_c; o_cdiff = char_diff_c;
         end
         if (!busy) begin o_hung = 0; break; end
         if (o_emit < f_drops) begin seg_valid = 1'b1; o_emit++; end
         if (mt_req) begin
            if (!prev_req) begin s++; req_cnt = 0; end
            in_wait = 0;
            if (s >= NC || mt_slot !== SW'(s)) o_slot_bad++;
            if (s < NC && req_cnt == f_ack[s]) begin
               mt_ack = 1'b1; in_wait = 1; wait_cnt = 0;
            end else if (f_spur) mt_done = 1'($urandom);
            req_cnt++;
         end else if (in_wait && !char_valid_c) begin
            if (s == stop_slot) begin seg_valid = 1'b0; o_hung = 0; return; end
            if (f_clr && wait_cnt == TO - 1) err_clr = 1'b1;
            if (f_done[s] == wait_cnt) begin
               mt_done = 1'b1; mt_index = f_idx[s]; mt_diff = f_dif[s];
            end else if (f_spur) mt_ack = 1'($urandom);
            wait_cnt++;
         end
         prev_req = mt_req;
      end
      seg_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_assert++;
      if ({seg_ready, mt_req, mt_slot, busy, char_valid_c, timeout_err, drop_cnt} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
         n_fail++; $display("FAIL reset_ctrl got=%b", {seg_ready, mt_req, mt_slot, busy, char_valid_c, timeout_err, drop_cnt});
      end
      n_assert++;
      if (char_index_c !== '0 || char_diff_c !== '0) begin
         n_fail++; $display("FAIL reset_bus got idx=%h diff=%h required 0", char_index_c, char_diff_c);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      set_slots(0, 0, 16'd10);
      run_frame(16'd100);
      model_frame(16'd100);
      n_assert++;
      if (o_hung || !o_valid) begin n_fail++; $display("FAIL basic_valid got=%0d required 1", o_valid); end
      n_assert++;
      if (o_lat != 2 * NC + 1) begin n_fail++; $display("FAIL basic_latency got=%0d required %0d", o_lat, 2 * NC + 1); end
      n_assert++;
      if (o_cidx !== 28'h1234567) begin n_fail++; $display("FAIL basic_index got=%h required 1234567", o_cidx); end
      n_assert++;
      if (o_cdiff !== {NC{16'd10}}) begin n_fail++; $display("FAIL basic_diff got=%h", o_cdiff); end
      n_assert++;
      if (char_index_c !== exp_idx || timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL basic_hold got idx=%h err=%b required %h 0", char_index_c, timeout_err, exp_idx);
      end
   endtask

   task automatic test_invalid_diff();
      set_slots(0, 0, 16'd10);
      f_idx[3] = 4'd5; f_dif[3] = 16'd200;
      run_frame(16'd100);
      model_frame(16'd100);
      n_assert++;
      if (o_hung || o_valid != exp_valid) begin n_fail++; $display("FAIL inval_valid got=%0d required %0d", o_valid, exp_valid); end
      n_assert++;
      if (char_index_c !== exp_idx || char_diff_c !== exp_diff) begin
         n_fail++; $display("FAIL inval_bus got idx=%h diff=%h required %h %h", char_index_c, char_diff_c, exp_idx, exp_diff);
      end
   endtask

   task automatic test_timeout();
      set_slots(0, 0, 16'd20);
      f_done[6] = -1;
      run_frame(16'd100);
      model_frame(16'd100);
      n_assert++;
      if (o_hung || o_valid != exp_valid || (exp_valid && o_lat != exp_lat)) begin
         n_fail++; $display("FAIL to_frame got valid=%0d lat=%0d required %0d %0d", o_valid, o_lat, exp_valid, exp_lat);
      end
      n_assert++;
      if (char_index_c !== exp_idx || char_diff_c !== exp_diff) begin
         n_fail++; $display("FAIL to_lane got idx=%h diff=%h required %h %h", char_index_c, char_diff_c, exp_idx, exp_diff);
      end
      n_assert++;
      if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set got=%b required 1", timeout_err); end
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0; exp_err = 0;
      n_assert++;
      if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clr got=%b required 0", timeout_err); end
      // result arriving on the expiry cycle must be kept
      set_slots(0, 0, 16'd30);
      f_done[2] = TO - 1; f_idx[2] = 4'd9;
      run_frame(16'd100);
      model_frame(16'd100);
      n_assert++;
      if (o_hung || !o_valid || char_index_c !== exp_idx || timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL to_done_wins got idx=%h err=%b required %h 0", char_index_c, timeout_err, exp_idx);
      end
      // clear coinciding with a timeout: the set must stick
      set_slots(0, 0, 16'd30);
      f_done[1] = -1; f_clr = 1;
      run_frame(16'd100);
      model_frame(16'd100);
      n_assert++;
      if (timeout_err !== exp_err) begin n_fail++; $display("FAIL to_set_wins got=%b required %b", timeout_err, exp_err); end
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0; exp_err = 0;
   endtask

   task automatic test_drop();
      set_slots(0, 0, 16'd5);
      f_drops = 3;
      run_frame(16'd100);
      model_frame(16'd100);
      n_assert++;
      if (drop_cnt !== 8'(exp_drop) || o_emit != 3) begin
         n_fail++; $display("FAIL drop_3 got=%0d required %0d", drop_cnt, exp_drop);
      end
      set_slots(50, 0, 16'd5);
      f_drops = 300;
      run_frame(16'd100);
      model_frame(16'd100);
      n_assert++;
      if (drop_cnt !== 8'd255 || o_emit != 300) begin
         n_fail++; $display("FAIL drop_sat got=%0d required 255 (pulses %0d)", drop_cnt, o_emit);
      end
   endtask

   task automatic test_ack_delay();
      set_slots(5, 0, 16'd10);
      for (int i = 0; i < NC; i++) f_idx[i] = 4'($urandom_range(0, 14));
      f_spur = 1;
      run_frame(16'd100);
      model_frame(16'd100);
      n_assert++;
      if (o_slot_bad != 0) begin n_fail++; $display("FAIL ack_slot_stable got=%0d bad cycles required 0", o_slot_bad); end
      n_assert++;
      if (o_hung || !o_valid || o_lat != exp_lat || o_cidx !== exp_idx) begin
         n_fail++; $display("FAIL ack_delay got lat=%0d idx=%h required %0d %h", o_lat, o_cidx, exp_lat, exp_idx);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < NC; i++) begin
            int sel;
            sel = $urandom_range(0, 11);
            f_ack[i]  = $urandom_range(0, 3);
            f_done[i] = (sel == 0) ? -1 : (sel == 1) ? TO - 1 : (sel == 2) ? TO + 2 : $urandom_range(0, 4);
            f_idx[i]  = 4'($urandom);
            f_dif[i]  = 16'($urandom_range(900, 1100));
         end
         f_spur = 1; f_clr = 1'($urandom); f_drops = $urandom_range(0, 3);
         run_frame(16'd1000);
         model_frame(16'd1000);
         n_assert++;
         if (o_hung || o_slot_bad != 0 || o_valid != exp_valid || (exp_valid && o_lat != exp_lat)) begin
            n_fail++; $display("FAIL rand_frame%0d got valid=%0d lat=%0d bad=%0d required %0d %0d", f, o_valid, o_lat, o_slot_bad, exp_valid, exp_lat);
         end
         n_assert++;
         if (char_index_c !== exp_idx || char_diff_c !== exp_diff) begin
            n_fail++; $display("FAIL rand_bus%0d got idx=%h diff=%h required %h %h", f, char_index_c, char_diff_c, exp_idx, exp_diff);
         end
         n_assert++;
         if (timeout_err !== exp_err || drop_cnt !== 8'(exp_drop)) begin
            n_fail++; $display("FAIL rand_status%0d got err=%b drop=%0d required %b %0d", f, timeout_err, drop_cnt, exp_err, exp_drop);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_slots(1, 1, 16'd40);
      stop_slot = 4;
      run_frame(16'd100);
      stop_slot = -1;
      #2 rst_n = 1'b0;
      #1;
      n_assert++;
      if ({seg_ready, mt_req, mt_slot, busy, char_valid_c, timeout_err, drop_cnt} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
         n_fail++; $display("FAIL midreset_ctrl got=%b", {seg_ready, mt_req, mt_slot, busy, char_valid_c, timeout_err, drop_cnt});
      end
      n_assert++;
      if (char_index_c !== '0 || char_diff_c !== '0) begin
         n_fail++; $display("FAIL midreset_bus got idx=%h diff=%h required 0", char_index_c, char_diff_c);
      end
      exp_idx = '0; exp_diff = '0; exp_err = 0; exp_drop = 0;
      @(negedge clk); rst_n = 1'b1;
      set_slots(0, 2, 16'd50);
      run_frame(16'd100);
      model_frame(16'd100);
      n_assert++;
      if (o_hung || !o_valid || o_lat != exp_lat || char_index_c !== exp_idx || char_diff_c !== exp_diff) begin
         n_fail++; $display("FAIL midreset_next got lat=%0d idx=%h required %0d %h", o_lat, char_index_c, exp_lat, exp_idx);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_invalid_diff();
      test_timeout();
      test_drop();
      test_ack_delay();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
